// File: rtl/move_sequencer.sv
// Host-fed move sequencer: buffers compass move codes, issues each as a one-hot
// direction pulse, and waits for the motor controller's done pulse before the next.
module move_sequencer #(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 50000000,
   parameter int CNT_W          = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   input  logic [2:0]                 cmd_code,
   output logic                       cmd_ready,
   input  logic                       start,
   input  logic                       abort,
   output logic [7:0]                 direction,
   input  logic                       done,
   output logic                       busy,
   output logic                       seq_done,
   output logic                       timeout_err,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic [7:0]                 moves_done
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_SETTLE, S_FINISH, S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        mem_q [0:DEPTH-1];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [CNT_W-1:0]  timer_q, timer_d, timer_inc;
   logic [7:0]        direction_q, direction_d, moves_q, moves_d;
   logic              busy_q, busy_d, seq_done_q, seq_done_d;
   logic              err_q, err_d, ready_q, ready_d;
   logic              wr_en, pop, flush;

   assign timer_inc = timer_q + 1'b1;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; abort overrides everything
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (start && count_q != '0) state_d = S_ISSUE;
            S_ISSUE:  state_d = S_WAIT;
            S_WAIT: begin
               // done wins over a timeout in the same cycle
               if (done)                                          state_d = S_SETTLE;
               else if (timer_inc == CNT_W'(TIMEOUT_CYCLES - 1))  state_d = S_ERROR;
            end
            S_SETTLE: if (!done) state_d = (count_q != '0) ? S_ISSUE : S_FINISH;
            S_FINISH: state_d = S_IDLE;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Output / datapath next values; every output is a registered copy of these
   always_comb begin
      pop      = (state_d == S_ISSUE);
      flush    = abort || (state_d == S_ERROR);
      wr_en    = cmd_valid && ready_q && !abort;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + AW'(wr_en);
         rd_ptr_d = rd_ptr_q + AW'(pop);
         count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      end
      timer_d     = (state_q == S_WAIT && state_d == S_WAIT) ? timer_inc : '0;
      direction_d = pop ? (8'b1 << mem_q[rd_ptr_q]) : 8'b0;
      moves_d     = moves_q;
      if (state_q == S_IDLE && state_d == S_ISSUE)       moves_d = '0;
      else if (state_q == S_WAIT && state_d == S_SETTLE) moves_d = moves_q + 8'd1;
      busy_d     = (state_d != S_IDLE);
      seq_done_d = (state_d == S_FINISH);
      err_d      = (state_d == S_ERROR);
      ready_d    = (count_d != (AW+1)'(DEPTH)) && (state_d != S_ERROR);
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= cmd_code;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         timer_q     <= '0;
         direction_q <= '0;
         moves_q     <= '0;
         busy_q      <= 1'b0;
         seq_done_q  <= 1'b0;
         err_q       <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         timer_q     <= timer_d;
         direction_q <= direction_d;
         moves_q     <= moves_d;
         busy_q      <= busy_d;
         seq_done_q  <= seq_done_d;
         err_q       <= err_d;
         ready_q     <= ready_d;
      end
   end

   assign cmd_ready   = ready_q;
   assign direction   = direction_q;
   assign busy        = busy_q;
   assign seq_done    = seq_done_q;
   assign timeout_err = err_q;
   assign fifo_count  = count_q;
   assign moves_done  = moves_q;
endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: expected direction pulses and seq_done
// pulses are queued by the stimulus and consumed by an independent monitor.
module tb_move_sequencer;
   localparam int DEPTH = 16;
   localparam int TMO   = 10;

   logic       clk, reset, cmd_valid, start, abort, done;
   logic [2:0] cmd_code;
   logic       cmd_ready, busy, seq_done, timeout_err;
   logic [7:0] direction, moves_done;
   logic [$clog2(DEPTH):0] fifo_count;

   move_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
      .cmd_ready(cmd_ready), .start(start), .abort(abort), .direction(direction),
      .done(done), .busy(busy), .seq_done(seq_done), .timeout_err(timeout_err),
      .fifo_count(fifo_count), .moves_done(moves_done)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_dir[$];
   int exp_seq = 0;
   logic prev_dir_hi = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_code(input logic [2:0] c);
      cmd_valid = 1'b1;
      cmd_code  = c;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic wait_dir(input string nm);
      int i;
      i = 0;
      while (direction == 8'h00 && i < 50) begin
         tick();
         i++;
      end
      if (direction == 8'h00) chk(nm, 32'h0, 32'h1);
   endtask

   task automatic wait_idle(input string nm);
      int i;
      i = 0;
      while (busy && i < 50) begin
         tick();
         i++;
      end
      chk(nm, busy, 1'b0);
   endtask

   // Monitor: every direction pulse and seq_done pulse must have been predicted
   always @(negedge clk) begin
      if (!reset) begin
         if (direction != 8'h00) begin
            if (prev_dir_hi) chk("dir_one_cycle", 32'h1, 32'h0);
            if (exp_dir.size() == 0) chk("dir_unexpected", direction, 8'h00);
            else chk("dir_value", direction, exp_dir.pop_front());
         end
         if (seq_done) begin
            if (exp_seq == 0) chk("seq_done_unexpected", 32'h1, 32'h0);
            else begin
               exp_seq--;
               n_cmp++;
            end
         end
         prev_dir_hi = (direction != 8'h00);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_code = '0;
      start = 1'b0; abort = 1'b0; done = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_direction", direction, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_seq_done", seq_done, 1'b0);
      chk("rst_err", timeout_err, 1'b0);
      chk("rst_count", fifo_count, 0);
      chk("rst_moves", moves_done, 0);
      chk("rst_ready", cmd_ready, 1'b1);

      // Three-move sequence, done 4 cycles after each pulse
      write_code(3'd0); write_code(3'd6); write_code(3'd5);
      chk("t1_count", fifo_count, 3);
      exp_dir.push_back(8'h01); exp_dir.push_back(8'h40); exp_dir.push_back(8'h20);
      exp_seq++;
      pulse_start();
      chk("t1_latency", direction, 8'h01);
      for (int m = 0; m < 3; m++) begin
         wait_dir("t1_wait_dir");
         repeat (4) tick();
         done = 1'b1;
         tick();
         done = 1'b0;
      end
      wait_idle("t1_idle");
      chk("t1_moves", moves_done, 3);
      chk("t1_count_end", fifo_count, 0);

      // Start with empty FIFO is ignored
      pulse_start();
      chk("t2_busy0", busy, 1'b0);
      repeat (4) tick();
      chk("t2_busy1", busy, 1'b0);
      chk("t2_moves_hold", moves_done, 3);

      // Fill beyond capacity
      for (int i = 0; i <= DEPTH; i++) begin
         chk("t3_ready", cmd_ready, (i < DEPTH));
         write_code(3'(i));
      end
      chk("t3_count_full", fifo_count, DEPTH);
      chk("t3_ready_full", cmd_ready, 1'b0);
      pulse_abort();
      chk("t3_count_flushed", fifo_count, 0);
      chk("t3_ready_after", cmd_ready, 1'b1);

      // done held for 5 cycles counts once
      write_code(3'd2); write_code(3'd7);
      exp_dir.push_back(8'h04); exp_dir.push_back(8'h80);
      exp_seq++;
      pulse_start();
      chk("t4_first", direction, 8'h04);
      tick();
      done = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t4_hold_dir", direction, 8'h00);
         chk("t4_hold_moves", moves_done, 1);
      end
      done = 1'b0;
      tick();
      chk("t4_dir_after_fall", direction, 8'h80);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      wait_idle("t4_idle");
      chk("t4_moves", moves_done, 2);

      // Watchdog: no done, second entry flushed
      write_code(3'd4); write_code(3'd3);
      exp_dir.push_back(8'h10);
      pulse_start();
      chk("t5_dir", direction, 8'h10);
      chk("t5_count", fifo_count, 1);
      for (int k = 1; k <= TMO; k++) begin
         tick();
         chk("t5_err_timing", timeout_err, (k >= TMO));
         chk("t5_dir_low", direction, 8'h00);
      end
      chk("t5_flushed", fifo_count, 0);
      chk("t5_ready_err", cmd_ready, 1'b0);
      write_code(3'd1);
      repeat (3) tick();
      chk("t5_no_write", fifo_count, 0);
      chk("t5_sticky", timeout_err, 1'b1);
      chk("t5_busy_err", busy, 1'b1);
      pulse_abort();
      chk("t5_err_clr", timeout_err, 1'b0);
      chk("t5_idle", busy, 1'b0);
      chk("t5_ready", cmd_ready, 1'b1);

      // Abort during WAIT_DONE with 2 entries queued
      write_code(3'd1); write_code(3'd3); write_code(3'd5); write_code(3'd6);
      exp_dir.push_back(8'h02); exp_dir.push_back(8'h08);
      pulse_start();
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      wait_dir("t6_wait_dir");
      chk("t6_dir2", direction, 8'h08);
      chk("t6_queued", fifo_count, 2);
      tick();
      pulse_abort();
      chk("t6_busy", busy, 1'b0);
      chk("t6_count", fifo_count, 0);
      chk("t6_moves_hold", moves_done, 1);
      done = 1'b1;
      tick();
      done = 1'b0;
      repeat (4) tick();
      chk("t6_busy_late", busy, 1'b0);
      chk("t6_moves_late", moves_done, 1);

      repeat (3) tick();
      chk("end_dir_queue", exp_dir.size(), 0);
      chk("end_seq_pending", exp_seq, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Initiator side of the motor-controller direction/done handshake.
- Buffers a host-supplied sequence of compass moves in a small FIFO and issues them one at a time as single-cycle one-hot direction pulses.
- Waits for the motor block's done pulse after each move, then issues the next.
- Sits between the host/game-logic interface and the motor controller. Adds a per-move watchdog and an abort path.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000000, max cycles allowed for one move before error; minimum 2.
- CNT_W, 32, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host presents a move code.
- cmd_code  in  3  move code: 0=N, 1=NW, 2=W, 3=SW, 4=S, 5=SE, 6=E, 7=NE.
- cmd_ready  out  1  FIFO can accept a code.
- start  in  1  single-cycle request to execute the buffered sequence.
- abort  in  1  cancel the sequence, flush the FIFO, clear the error.
- direction  out  8  one-hot move pulse to the motor controller; bit k = code k.
- done  in  1  move-complete pulse from the motor controller.
- busy  out  1  high in every state except IDLE.
- seq_done  out  1  one-cycle pulse when the whole sequence completes.
- timeout_err  out  1  sticky watchdog error flag.
- fifo_count  out  clog2(DEPTH)+1  entries currently buffered.
- moves_done  out  8  moves completed since the last accepted start; wraps at 255 to 0.

Behaviour:
- All outputs are registered.
- Reset values: direction=0, busy=0, seq_done=0, timeout_err=0, fifo_count=0, moves_done=0, cmd_ready=1. State=IDLE, FIFO empty, pointers 0.
- Reset overrides every other input.

FIFO:
- A write occurs when cmd_valid && cmd_ready.
- cmd_ready = !full && state!=ERROR && !abort.
- Writes are accepted in any state except ERROR, so the host may append while a sequence runs.
- A write and a pop in the same cycle leave fifo_count unchanged.
- Pointers wrap modulo DEPTH.
- A write while full is not accepted, and the FIFO is left unchanged.

State machine:
- IDLE:
  - start && fifo_count>0 -> ISSUE; moves_done cleared to 0.
  - start with an empty FIFO is ignored: no seq_done pulse, state stays IDLE.
  - start in any other state is ignored.
- ISSUE (1 cycle):
  - direction = 1<<head, pop the head, timer cleared -> WAIT_DONE.
  - direction is high for exactly one cycle.
  - Latency: start accepted at cycle n, direction high at cycle n+1.
- WAIT_DONE:
  - direction=0; timer increments each cycle.
  - done=1 -> moves_done+1 -> SETTLE.
  - timer reaching TIMEOUT_CYCLES-1 without done -> ERROR.
  - If done and the timeout occur in the same cycle, done wins.
- SETTLE:
  - Wait for done=0, so that a done held high for several cycles counts once.
  - On done=0: fifo_count>0 -> ISSUE, else -> FINISH.
  - Minimum gap between successive direction pulses: 3 cycles.
- FINISH (1 cycle): seq_done=1 -> IDLE.
- ERROR:
  - timeout_err=1 (sticky), direction=0, FIFO flushed.
  - Stays in ERROR until reset or abort.
- done received in IDLE, ISSUE or FINISH is ignored.

abort:
- In any state, the next state is IDLE: FIFO flushed, direction=0, timeout_err cleared, timer cleared, no seq_done pulse.
- moves_done holds its value.
- abort wins over a simultaneous start, write or done.

Test Plan:
- Write codes 0,6,5 then pulse start; answer each pulse with done 4 cycles later -> direction shows 0x01, 0x40, 0x20 in order, one cycle each; seq_done pulses once after the third done; moves_done=3; fifo_count=0.
- Start with an empty FIFO -> no direction pulse, busy stays 0, no seq_done.
- Write DEPTH+1 codes with no start -> cmd_ready drops after 16 writes, the 17th is not accepted, fifo_count=16.
- Hold done high for 5 cycles on move 1 of 2 -> moves_done increments once; move 2 is issued only after done falls.
- TIMEOUT_CYCLES=10, no done -> timeout_err=1 at 10 cycles after the direction pulse, FIFO flushed, direction stays 0. Then abort -> timeout_err=0, state IDLE.
- Assert abort in WAIT_DONE with 2 entries queued -> busy=0 next cycle, fifo_count=0; a later done is ignored and no seq_done pulse occurs.
